core_bus_arbiter: RTL and testbench

Two-master to one-slave Avalon-MM arbiter that merges the core's instruction bus and data bus onto a single memory port. It sits directly downstream of `veriRISCV_core`, between its `ibus_avalon_*` / `dbus_avalon_*` ports and the shared on-chip memory / interconnect. It locks a grant for the duration of a stalled request and tracks outstanding pipelined reads in an in-order ID FIFO, so that each `readdatavalid` is routed back to the master that issued the read.

---
 rtl/core_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// Two-master (ibus/dbus) to one-slave Avalon-MM arbiter with a grant lock and an in-order read ID FIFO.
// Define CORE_BUS_ARB_RR_EN for round-robin arbitration; the default build uses fixed dbus priority.
module core_bus_arbiter #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_avalon_req_read,
  input  logic        ibus_avalon_req_write,
  input  logic [31:0] ibus_avalon_req_address,
  input  logic [31:0] ibus_avalon_req_writedata,
  input  logic [3:0]  ibus_avalon_req_byte_enable,
  output logic [31:0] ibus_avalon_resp_readdata,
  output logic        ibus_avalon_resp_waitrequest,
  output logic        ibus_avalon_resp_readdatavalid,
  input  logic        dbus_avalon_req_read,
  input  logic        dbus_avalon_req_write,
  input  logic [31:0] dbus_avalon_req_address,
  input  logic [31:0] dbus_avalon_req_writedata,
  input  logic [3:0]  dbus_avalon_req_byte_enable,
  output logic [31:0] dbus_avalon_resp_readdata,
  output logic        dbus_avalon_resp_waitrequest,
  output logic        dbus_avalon_resp_readdatavalid,
  output logic        mem_avalon_req_read,
  output logic        mem_avalon_req_write,
  output logic [31:0] mem_avalon_req_address,
  output logic [31:0] mem_avalon_req_writedata,
  output logic [3:0]  mem_avalon_req_byte_enable,
  input  logic [31:0] mem_avalon_resp_readdata,
  input  logic        mem_avalon_resp_waitrequest,
  input  logic        mem_avalon_resp_readdatavalid,
  output logic        err_rvalid_orphan
);

  localparam int PTR_W = (MAX_PENDING > 2) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t               state_q, state_d;
  logic [MAX_PENDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     pending_q, pending_d;
  logic                 err_q, err_d;

  logic i_req, d_req, i_can, d_can, full;
  logic gnt_valid, gnt_dbus, pick_dbus;
  logic sel_read, sel_write, fwd, accepted;
  logic push, pop, orphan, head_dbus;

`ifdef CORE_BUS_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // last_owner = 1 means dbus was the last accepted owner.
  assign pick_dbus    = ~last_owner_q;
  assign last_owner_d = accepted ? gnt_dbus : last_owner_q;

  always_ff @(posedge clk) begin
    if (rst) last_owner_q <= 1'b0;
    else     last_owner_q <= last_owner_d;
  end
`else
  assign pick_dbus = 1'b1;
`endif

  always_comb begin
    i_req = ibus_avalon_req_read | ibus_avalon_req_write;
    d_req = dbus_avalon_req_read | dbus_avalon_req_write;
    full  = (pending_q == CNT_W'(MAX_PENDING));
    // A throttled read does not compete, so a write from the other master can still proceed.
    i_can = ibus_avalon_req_write | (ibus_avalon_req_read & ~full);
    d_can = dbus_avalon_req_write | (dbus_avalon_req_read & ~full);

    gnt_valid = 1'b0;
    gnt_dbus  = 1'b0;
    case (state_q)
      LOCK_I: begin
        gnt_valid = i_can;
        gnt_dbus  = 1'b0;
      end
      LOCK_D: begin
        gnt_valid = d_can;
        gnt_dbus  = 1'b1;
      end
      default: begin
        if (i_can && d_can) begin
          gnt_valid = 1'b1;
          gnt_dbus  = pick_dbus;
        end else if (d_can) begin
          gnt_valid = 1'b1;
          gnt_dbus  = 1'b1;
        end else if (i_can) begin
          gnt_valid = 1'b1;
          gnt_dbus  = 1'b0;
        end
      end
    endcase

    sel_read  = gnt_dbus ? dbus_avalon_req_read  : ibus_avalon_req_read;
    sel_write = gnt_dbus ? dbus_avalon_req_write : ibus_avalon_req_write;

    mem_avalon_req_read        = ~rst & gnt_valid & sel_read & ~full;
    mem_avalon_req_write       = ~rst & gnt_valid & sel_write;
    mem_avalon_req_address     = gnt_dbus ? dbus_avalon_req_address     : ibus_avalon_req_address;
    mem_avalon_req_writedata   = gnt_dbus ? dbus_avalon_req_writedata   : ibus_avalon_req_writedata;
    mem_avalon_req_byte_enable = gnt_dbus ? dbus_avalon_req_byte_enable : ibus_avalon_req_byte_enable;

    fwd      = mem_avalon_req_read | mem_avalon_req_write;
    accepted = fwd & ~mem_avalon_resp_waitrequest;

    ibus_avalon_resp_waitrequest = ~(fwd & ~gnt_dbus) | mem_avalon_resp_waitrequest;
    dbus_avalon_resp_waitrequest = ~(fwd &  gnt_dbus) | mem_avalon_resp_waitrequest;

    state_d = state_q;
    case (state_q)
      LOCK_I:  if (!i_req || accepted) state_d = IDLE;
      LOCK_D:  if (!d_req || accepted) state_d = IDLE;
      default: if (fwd && mem_avalon_resp_waitrequest) state_d = gnt_dbus ? LOCK_D : LOCK_I;
    endcase
  end

  always_comb begin
    push      = accepted & mem_avalon_req_read;
    pop       = mem_avalon_resp_readdatavalid & (pending_q != '0);
    orphan    = mem_avalon_resp_readdatavalid & (pending_q == '0);
    head_dbus = fifo_q[rd_ptr_q];

    ibus_avalon_resp_readdatavalid = ~rst & pop & ~head_dbus;
    dbus_avalon_resp_readdatavalid = ~rst & pop &  head_dbus;
    ibus_avalon_resp_readdata      = mem_avalon_resp_readdata;
    dbus_avalon_resp_readdata      = mem_avalon_resp_readdata;

    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    pending_d = pending_q + CNT_W'(push) - CNT_W'(pop);
    err_d     = err_q | orphan;
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PENDING; gi++) begin : g_fifo
      assign fifo_d[gi] = (push && (wr_ptr_q == PTR_W'(gi))) ? gnt_dbus : fifo_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign err_rvalid_orphan = err_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: a queue-based reference model checked every cycle plus literal spot checks.
module tb_core_bus_arbiter;
  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir, iw, dr, dw;
  logic [31:0] ia, iwd, da, dwd;
  logic [3:0]  ibe, dbe;
  logic [31:0] i_rdata, d_rdata;
  logic        i_wait, i_rv, d_wait, d_rv;
  logic        m_rd, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_wait, m_rv;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_bus_arbiter #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst(rst),
    .ibus_avalon_req_read(ir), .ibus_avalon_req_write(iw), .ibus_avalon_req_address(ia),
    .ibus_avalon_req_writedata(iwd), .ibus_avalon_req_byte_enable(ibe),
    .ibus_avalon_resp_readdata(i_rdata), .ibus_avalon_resp_waitrequest(i_wait),
    .ibus_avalon_resp_readdatavalid(i_rv),
    .dbus_avalon_req_read(dr), .dbus_avalon_req_write(dw), .dbus_avalon_req_address(da),
    .dbus_avalon_req_writedata(dwd), .dbus_avalon_req_byte_enable(dbe),
    .dbus_avalon_resp_readdata(d_rdata), .dbus_avalon_resp_waitrequest(d_wait),
    .dbus_avalon_resp_readdatavalid(d_rv),
    .mem_avalon_req_read(m_rd), .mem_avalon_req_write(m_wr), .mem_avalon_req_address(m_addr),
    .mem_avalon_req_writedata(m_wdata), .mem_avalon_req_byte_enable(m_be),
    .mem_avalon_resp_readdata(m_rdata), .mem_avalon_resp_waitrequest(m_wait),
    .mem_avalon_resp_readdatavalid(m_rv),
    .err_rvalid_orphan(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of read owners (0 = ibus, 1 = dbus), locked owner, last owner, sticky error.
  bit q[$];
  int lock_owner = -1;
  int last_owner = 0;
  bit err_m = 1'b0;
  bit rr_en;

  initial begin
`ifdef CORE_BUS_ARB_RR_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
  end

  always @(negedge clk) begin
    bit full, ican, dcan, fwd, acc, exp_rd, exp_wr, o_read, o_write;
    int owner;
    logic [31:0] o_addr, o_wd;
    logic [3:0]  o_be;
    if (rst) begin
      chk("rst_mem_read", {31'd0, m_rd}, 32'd0);
      chk("rst_mem_write", {31'd0, m_wr}, 32'd0);
      chk("rst_ibus_wait", {31'd0, i_wait}, 32'd1);
      chk("rst_dbus_wait", {31'd0, d_wait}, 32'd1);
      chk("rst_ibus_rvalid", {31'd0, i_rv}, 32'd0);
      chk("rst_dbus_rvalid", {31'd0, d_rv}, 32'd0);
      q.delete();
      lock_owner = -1;
      last_owner = 0;
      err_m = 1'b0;
    end else begin
      chk("m_err", {31'd0, err}, {31'd0, err_m});
      full = (q.size() == MAXP);
      ican = iw | (ir & !full);
      dcan = dw | (dr & !full);
      owner = -1;
      if (lock_owner == 0) owner = ican ? 0 : -1;
      else if (lock_owner == 1) owner = dcan ? 1 : -1;
      else if (ican && dcan) owner = rr_en ? ((last_owner == 0) ? 1 : 0) : 1;
      else if (dcan) owner = 1;
      else if (ican) owner = 0;
      fwd = (owner >= 0);
      o_read  = (owner == 1) ? dr  : ir;
      o_write = (owner == 1) ? dw  : iw;
      o_addr  = (owner == 1) ? da  : ia;
      o_wd    = (owner == 1) ? dwd : iwd;
      o_be    = (owner == 1) ? dbe : ibe;
      exp_rd = fwd && o_read && !full;
      exp_wr = fwd && o_write;
      chk("m_mem_read", {31'd0, m_rd}, {31'd0, exp_rd});
      chk("m_mem_write", {31'd0, m_wr}, {31'd0, exp_wr});
      if (fwd) begin
        chk("m_mem_addr", m_addr, o_addr);
        chk("m_mem_wdata", m_wdata, o_wd);
        chk("m_mem_be", {28'd0, m_be}, {28'd0, o_be});
      end
      chk("m_ibus_wait", {31'd0, i_wait}, {31'd0, (fwd && owner == 0) ? m_wait : 1'b1});
      chk("m_dbus_wait", {31'd0, d_wait}, {31'd0, (fwd && owner == 1) ? m_wait : 1'b1});
      chk("m_ibus_rvalid", {31'd0, i_rv}, {31'd0, m_rv && q.size() > 0 && q[0] == 1'b0});
      chk("m_dbus_rvalid", {31'd0, d_rv}, {31'd0, m_rv && q.size() > 0 && q[0] == 1'b1});
      chk("m_ibus_rdata", i_rdata, m_rdata);
      chk("m_dbus_rdata", d_rdata, m_rdata);
      acc = fwd && !m_wait;
      if (m_rv) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (acc && exp_rd) q.push_back(owner == 1);
      if (lock_owner < 0) begin
        if (fwd && m_wait) lock_owner = owner;
      end else if (((lock_owner == 0) ? !(ir | iw) : !(dr | dw)) || acc) begin
        lock_owner = -1;
      end
      if (acc) last_owner = owner;
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rr_exp [4];
    rst = 1'b1;
    ir = 1'b1; iw = 1'b0; dr = 1'b0; dw = 1'b0;
    ia = 32'h0; iwd = 32'h0; ibe = 4'hF; da = 32'h0; dwd = 32'h0; dbe = 4'hF;
    m_wait = 1'b0; m_rv = 1'b0; m_rdata = 32'h0;
    neg;
    chk("reset_mem_read", {31'd0, m_rd}, 32'd0);
    nxt;
    ir = 1'b0;
    nxt;
    rst = 1'b0;
    nxt;

    // Single ibus read with slave latency 2.
    ir = 1'b1; ia = 32'h100;
    neg;
    chk("t1_mem_read", {31'd0, m_rd}, 32'd1);
    chk("t1_mem_addr", m_addr, 32'h100);
    chk("t1_ibus_wait", {31'd0, i_wait}, 32'd0);
    nxt; ir = 1'b0;
    nxt; m_rv = 1'b1; m_rdata = 32'hDEADBEEF;
    neg;
    chk("t1_ibus_rvalid", {31'd0, i_rv}, 32'd1);
    chk("t1_ibus_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_dbus_rvalid", {31'd0, d_rv}, 32'd0);
    nxt; m_rv = 1'b0;

    // Grant lock: dbus wins and holds the port through 3 stalled cycles.
    ir = 1'b1; ia = 32'h200; dr = 1'b1; da = 32'h300; m_wait = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) m_wait = 1'b0;
      neg;
      chk("t2_lock_addr", m_addr, 32'h300);
      chk("t2_lock_ibus_wait", {31'd0, i_wait}, 32'd1);
      nxt;
    end
    dr = 1'b0;
    neg;
    chk("t2_ibus_addr", m_addr, 32'h200);
    chk("t2_ibus_wait", {31'd0, i_wait}, 32'd0);
    nxt; ir = 1'b0;
    m_rv = 1'b1; m_rdata = 32'h11;
    neg;
    chk("t2_rv0_dbus", {31'd0, d_rv}, 32'd1);
    nxt; m_rdata = 32'h22;
    neg;
    chk("t2_rv1_ibus", {31'd0, i_rv}, 32'd1);
    nxt; m_rv = 1'b0;

    // Interleaved I, D, I reads with slave latency 3.
    ir = 1'b1; ia = 32'h400;
    nxt; ir = 1'b0; dr = 1'b1; da = 32'h500;
    nxt; dr = 1'b0; ir = 1'b1; ia = 32'h404;
    nxt; ir = 1'b0; m_rv = 1'b1; m_rdata = 32'hA0;
    neg;
    chk("t3_beat0_ibus", {31'd0, i_rv}, 32'd1);
    chk("t3_beat0_data", i_rdata, 32'hA0);
    nxt; m_rdata = 32'hB0;
    neg;
    chk("t3_beat1_dbus", {31'd0, d_rv}, 32'd1);
    chk("t3_beat1_data", d_rdata, 32'hB0);
    nxt; m_rdata = 32'hC0;
    neg;
    chk("t3_beat2_ibus", {31'd0, i_rv}, 32'd1);
    chk("t3_beat2_data", i_rdata, 32'hC0);
    nxt; m_rv = 1'b0;

    // Throttle at MAX_PENDING outstanding reads; writes still pass.
    ir = 1'b1; ia = 32'h600;
    for (int k = 0; k < 4; k++) begin
      neg;
      chk("t4_read_accept", {31'd0, m_rd}, 32'd1);
      nxt;
    end
    dw = 1'b1; da = 32'h700; dwd = 32'hCAFE0000; dbe = 4'h3;
    neg;
    chk("t4_held_read", {31'd0, m_rd}, 32'd0);
    chk("t4_held_wait", {31'd0, i_wait}, 32'd1);
    chk("t4_write_fwd", {31'd0, m_wr}, 32'd1);
    chk("t4_write_wait", {31'd0, d_wait}, 32'd0);
    nxt; dw = 1'b0; m_rv = 1'b1; m_rdata = 32'h1;
    neg;
    chk("t4_pop_still_held", {31'd0, m_rd}, 32'd0);
    chk("t4_pop_ibus", {31'd0, i_rv}, 32'd1);
    nxt; m_rv = 1'b0;
    neg;
    chk("t4_fifth_read", {31'd0, m_rd}, 32'd1);
    chk("t4_fifth_wait", {31'd0, i_wait}, 32'd0);
    nxt; ir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_rv = 1'b1; m_rdata = 32'h10 + k;
      neg;
      chk("t4_drain_ibus", {31'd0, i_rv}, 32'd1);
      nxt;
    end
    m_rv = 1'b0;

    // Both masters issue zero-wait writes continuously.
    rr_exp[0] = 32'h20; rr_exp[1] = rr_en ? 32'h10 : 32'h20;
    rr_exp[2] = 32'h20; rr_exp[3] = rr_en ? 32'h10 : 32'h20;
    iw = 1'b1; ia = 32'h10; iwd = 32'h1111; dw = 1'b1; da = 32'h20; dwd = 32'h2222; dbe = 4'hF;
    for (int k = 0; k < 4; k++) begin
      neg;
      chk("t5_grant_addr", m_addr, rr_exp[k]);
      nxt;
    end
    iw = 1'b0; dw = 1'b0;

    // Orphan readdatavalid, then reset clears the flag.
    m_rv = 1'b1; m_rdata = 32'h55;
    neg;
    chk("t6_orphan_ibus", {31'd0, i_rv}, 32'd0);
    chk("t6_orphan_dbus", {31'd0, d_rv}, 32'd0);
    nxt; m_rv = 1'b0;
    neg;
    chk("t6_err_set", {31'd0, err}, 32'd1);
    nxt; rst = 1'b1;
    nxt; rst = 1'b0; ir = 1'b1; ia = 32'h800;
    neg;
    chk("t6_err_clear", {31'd0, err}, 32'd0);
    chk("t6_idle_read", {31'd0, m_rd}, 32'd1);
    chk("t6_idle_wait", {31'd0, i_wait}, 32'd0);

    // That read is outstanding when reset hits; its late response is orphaned.
    nxt; ir = 1'b0; rst = 1'b1;
    nxt; rst = 1'b0; m_rv = 1'b1;
    neg;
    chk("t7_stale_ibus", {31'd0, i_rv}, 32'd0);
    nxt; m_rv = 1'b0;
    neg;
    chk("t7_err_set", {31'd0, err}, 32'd1);
    nxt;
    nxt;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
